// File: rtl/mmu_port_arbiter.sv
// mmu_port_arbiter
//   Shares the MMU's single virtual-side line port between two requesters:
//   port 0 is the data cache (refill/writeback), port 1 the instruction cache
//   (refill). One owner is granted per transaction. The owner's addr/data/rd/we
//   are passed to the MMU, and the MMU's ack and page-fault indications are
//   steered back to the owner only. A watchdog releases a grant that never
//   completes, and the owner sees a one-cycle timeout pulse when that happens.
//
//   Build option: define MMU_ARB_RR_EN to arbitrate ties round-robin. Without
//   it, port 0 always wins a tie.
//
// Parameters
//   TIMEOUT_CYCLES  BUSY cycles without m_ack_i before forced release (>= 2)
//   TO_BITS         watchdog counter width; must be able to hold TIMEOUT_CYCLES
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   rN_addr_i, rN_data_i        requester virtual line address / write line
//   rN_rd_i, rN_we_i            read / write request, held until ack
//   rN_data_o                   read line (m_data_i broadcast to both ports)
//   rN_ack_o, rN_pfault_o       transaction done / hw page fault, owner only
//   rN_timeout_o                one-cycle pulse: watchdog released this owner
//   m_addr_o, m_data_o          to MMU: address / write line
//   m_rd_o, m_we_o              to MMU: read / write strobe
//   m_data_i, m_ack_i           from MMU: read line / ack (combinational in MMU)
//   m_pfault_i                  from MMU: hw page fault
//   grant_o, busy_o             current owner (valid while busy_o), BUSY state

module mmu_port_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned TO_BITS        = 11
) (
    input  logic         clk,
    input  logic         rst,

    // Requester 0: data cache
    input  logic [31:0]  r0_addr_i,
    input  logic [255:0] r0_data_i,
    input  logic         r0_rd_i,
    input  logic         r0_we_i,
    output logic [255:0] r0_data_o,
    output logic         r0_ack_o,
    output logic         r0_pfault_o,
    output logic         r0_timeout_o,

    // Requester 1: instruction cache
    input  logic [31:0]  r1_addr_i,
    input  logic [255:0] r1_data_i,
    input  logic         r1_rd_i,
    input  logic         r1_we_i,
    output logic [255:0] r1_data_o,
    output logic         r1_ack_o,
    output logic         r1_pfault_o,
    output logic         r1_timeout_o,

    // MMU side
    output logic [31:0]  m_addr_o,
    output logic [255:0] m_data_o,
    output logic         m_rd_o,
    output logic         m_we_o,
    input  logic [255:0] m_data_i,
    input  logic         m_ack_i,
    input  logic         m_pfault_i,

    // Status
    output logic         grant_o,
    output logic         busy_o
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StBusy = 2'd1;
    localparam logic [1:0] StGap  = 2'd2;

    localparam logic [TO_BITS-1:0] WdLast = TO_BITS'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_BITS-1:0] WdOne  = TO_BITS'(1);

    logic [1:0]         state_q, state_d;
    logic               owner_q, owner_d;
    logic [TO_BITS-1:0] wd_q, wd_d;
    logic [31:0]        addr_hold_q, addr_hold_d;
    logic [255:0]       data_hold_q, data_hold_d;

    logic               req0, req1;
    logic               win;
    logic               in_busy;
    logic               own_rd, own_we, own_req;
    logic [31:0]        own_addr;
    logic [255:0]       own_data;
    logic               ack_v, pfault_v, expire;

    always_comb begin
        req0 = r0_rd_i | r0_we_i;
        req1 = r1_rd_i | r1_we_i;
    end

`ifdef MMU_ARB_RR_EN
    // rr_q remembers the last granted port; a tie goes to the other one.
    logic rr_q, rr_d;

    always_comb begin
        win = (req0 && req1) ? ~rr_q : req1;
    end
`else
    // Port 0 wins whenever it requests.
    always_comb begin
        win = ~req0;
    end
`endif

    // Owner-side view of the request
    always_comb begin
        in_busy  = (state_q == StBusy);
        own_rd   = owner_q ? r1_rd_i   : r0_rd_i;
        own_we   = owner_q ? r1_we_i   : r0_we_i;
        own_addr = owner_q ? r1_addr_i : r0_addr_i;
        own_data = owner_q ? r1_data_i : r0_data_i;
        own_req  = own_rd | own_we;

        // A dropped request (abort) returns nothing to the owner.
        ack_v    = in_busy & own_req & m_ack_i;
        pfault_v = in_busy & own_req & m_pfault_i;
        // Ack on the expiry cycle wins over the watchdog.
        expire   = in_busy & own_req & ~m_ack_i & (wd_q == WdLast);
    end

    // Outputs
    always_comb begin
        m_rd_o       = in_busy & own_rd;
        m_we_o       = in_busy & own_we;
        // Outside BUSY the last owner's values are held; they carry no meaning.
        m_addr_o     = in_busy ? own_addr : addr_hold_q;
        m_data_o     = in_busy ? own_data : data_hold_q;

        r0_data_o    = m_data_i;
        r1_data_o    = m_data_i;

        r0_ack_o     = ack_v    & ~owner_q;
        r1_ack_o     = ack_v    &  owner_q;
        r0_pfault_o  = pfault_v & ~owner_q;
        r1_pfault_o  = pfault_v &  owner_q;
        r0_timeout_o = expire   & ~owner_q;
        r1_timeout_o = expire   &  owner_q;

        grant_o      = owner_q;
        busy_o       = in_busy;
    end

    // Next state
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        wd_d        = wd_q;
        addr_hold_d = in_busy ? own_addr : addr_hold_q;
        data_hold_d = in_busy ? own_data : data_hold_q;
`ifdef MMU_ARB_RR_EN
        rr_d        = rr_q;
`endif

        case (state_q)
            StIdle: begin
                if (req0 || req1) begin
                    owner_d = win;
                    wd_d    = '0;
                    state_d = StBusy;
`ifdef MMU_ARB_RR_EN
                    rr_d    = win;
`endif
                end
            end

            StBusy: begin
                // Leave on ack, abort (owner dropped both strobes) or expiry.
                if (!own_req || m_ack_i || expire) begin
                    state_d = StGap;
                end else begin
                    wd_d = wd_q + WdOne;
                end
            end

            // One dead cycle so the MMU always sees its strobe fall.
            StGap: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            owner_q     <= 1'b0;
            wd_q        <= '0;
            addr_hold_q <= '0;
            data_hold_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            wd_q        <= wd_d;
            addr_hold_q <= addr_hold_d;
            data_hold_q <= data_hold_d;
        end
    end

`ifdef MMU_ARB_RR_EN
    // Reset to 1 so that port 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q <= 1'b1;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

endmodule
